// File: rtl/rv32_pkg.sv
// Shared core definitions: LSU width codes, LSU fault causes and the
// write-back / branch selector types used by the decoder.
package rv32_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;

    localparam logic [1:0] FAULT_ILLEGAL  = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_BUS      = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        WB_SOURCE_ALU = 2'd0,
        WB_SOURCE_LSU = 2'd1,
        WB_SOURCE_PC4 = 2'd2,
        WB_SOURCE_IMM = 2'd3
    } wb_source_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6,
        BR_JUMP = 3'd7
    } br_condition_t;

    // Unsigned widths exist only for loads; bit 3 is reserved.
    function automatic logic lsu_illegal(input logic [3:0] req, input logic wr);
        logic bad;
        case (req[2:0])
            LSU_LB, LSU_LH, LSU_LW: bad = 1'b0;
            LSU_LBU, LSU_LHU:       bad = wr;
            default:                bad = 1'b1;
        endcase
        return bad | req[3];
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/rv32_mod_lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store replication and
// load lane extraction with sign/zero extension.
module rv32_mod_lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_bus_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_lane;

    assign w_lane = i_bus_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_lane;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_funct3[2] ? {24'b0, w_lane[7:0]}
                                      : {{24{w_lane[7]}}, w_lane[7:0]};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_funct3[2] ? {16'b0, w_lane[15:0]}
                                      : {{16{w_lane[15]}}, w_lane[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32_mod_load_store_unit.sv
// Memory-access stage: validates a load/store, runs one req/ack bus
// transaction with timeout, and returns extended load data or a fault.
module rv32_mod_load_store_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [3:0]  i_ram_req,
    input  logic        i_ram_wr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic [1:0]  o_fault_cause,
    output logic [31:0] o_fault_addr,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t      r_state, w_state;
    logic [2:0]  r_f3, w_f3_nxt;
    logic        r_wr, w_wr_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic        r_busy, r_done, r_fault, r_bus_req, r_bus_we;
    logic [31:0] r_rdata, r_fault_addr, r_bus_addr, r_bus_wdata;
    logic [1:0]  r_cause;
    logic [3:0]  r_bus_be;

    logic        w_busy, w_done, w_fault, w_bus_req, w_bus_we;
    logic [31:0] w_rdata, w_fault_addr, w_bus_addr, w_bus_wdata;
    logic [1:0]  w_cause;
    logic [3:0]  w_bus_be;

    logic [2:0]  w_al_f3;
    logic [1:0]  w_al_lo;
    logic [3:0]  w_al_be;
    logic [31:0] w_al_wdata, w_al_rdata;

    // Incoming request drives the lane logic at accept; latched copy during BUS.
    assign w_al_f3 = (r_state == S_IDLE) ? i_ram_req[2:0] : r_f3;
    assign w_al_lo = (r_state == S_IDLE) ? i_addr[1:0]    : r_addr[1:0];

    rv32_mod_lsu_align u_align (
        .i_funct3    (w_al_f3),
        .i_addr_lo   (w_al_lo),
        .i_wdata     (i_wdata),
        .i_bus_rdata (i_bus_rdata),
        .o_be        (w_al_be),
        .o_wdata     (w_al_wdata),
        .o_rdata     (w_al_rdata)
    );

    always_comb begin
        w_state      = r_state;
        w_f3_nxt     = r_f3;
        w_wr_nxt     = r_wr;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_rdata      = '0;
        w_fault      = 1'b0;
        w_cause      = FAULT_ILLEGAL;
        w_fault_addr = '0;
        w_bus_req    = 1'b0;
        w_bus_we     = 1'b0;
        w_bus_addr   = '0;
        w_bus_be     = '0;
        w_bus_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_f3_nxt   = i_ram_req[2:0];
                    w_wr_nxt   = i_ram_wr;
                    w_addr_nxt = i_addr;
                    w_busy     = 1'b1;
                    if (lsu_illegal(i_ram_req, i_ram_wr) ||
                        lsu_misaligned(i_ram_req[2:0], i_addr[1:0])) begin
                        w_state      = S_DONE;
                        w_done       = 1'b1;
                        w_fault      = 1'b1;
                        w_cause      = lsu_illegal(i_ram_req, i_ram_wr) ? FAULT_ILLEGAL
                                                                        : FAULT_MISALIGN;
                        w_fault_addr = i_addr;
                    end else begin
                        w_state     = S_BUS;
                        w_cnt_nxt   = CW'(1);
                        w_bus_req   = 1'b1;
                        w_bus_we    = i_ram_wr;
                        w_bus_addr  = {i_addr[31:2], 2'b00};
                        w_bus_be    = w_al_be;
                        w_bus_wdata = w_al_wdata;
                    end
                end
            end
            S_BUS: begin
                w_busy = 1'b1;
                if (i_bus_err) begin
                    w_state      = S_DONE;
                    w_done       = 1'b1;
                    w_fault      = 1'b1;
                    w_cause      = FAULT_BUS;
                    w_fault_addr = r_addr;
                end else if (i_bus_ack) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    w_rdata = r_wr ? 32'b0 : w_al_rdata;
                end else if ((TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT))) begin
                    w_state      = S_DONE;
                    w_done       = 1'b1;
                    w_fault      = 1'b1;
                    w_cause      = FAULT_TIMEOUT;
                    w_fault_addr = r_addr;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_bus_req   = r_bus_req;
                    w_bus_we    = r_bus_we;
                    w_bus_addr  = r_bus_addr;
                    w_bus_be    = r_bus_be;
                    w_bus_wdata = r_bus_wdata;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_f3         <= '0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rdata      <= '0;
            r_fault      <= 1'b0;
            r_cause      <= '0;
            r_fault_addr <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
        end else begin
            r_state      <= w_state;
            r_f3         <= w_f3_nxt;
            r_wr         <= w_wr_nxt;
            r_addr       <= w_addr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_rdata      <= w_rdata;
            r_fault      <= w_fault;
            r_cause      <= w_cause;
            r_fault_addr <= w_fault_addr;
            r_bus_req    <= w_bus_req;
            r_bus_we     <= w_bus_we;
            r_bus_addr   <= w_bus_addr;
            r_bus_be     <= w_bus_be;
            r_bus_wdata  <= w_bus_wdata;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_rdata       = r_rdata;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_cause;
    assign o_fault_addr  = r_fault_addr;
    assign o_bus_req     = r_bus_req;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_be      = r_bus_be;
    assign o_bus_wdata   = r_bus_wdata;

endmodule
